// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int bit_width, input int chunk_width);
        return bit_width / chunk_width;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Combinational unsigned adder; overflow is the carry-out of the MSB.
module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    always_comb begin
        {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
    end

endmodule

// File: rtl/serial_adder_nbit.sv
// Multi-cycle unsigned adder: CHUNK_WIDTH bits per clock, carry held between chunks,
// optional accumulate into the registered sum.
//
// state | meaning
// IDLE  | waiting for start; sum/overflow hold the last result
// ADD   | one chunk added per cycle, busy high
// DONE  | one-cycle done pulse; start here chains the next operation
module serial_adder_nbit
    import serial_adder_pkg::*;
#(
    parameter int BIT_WIDTH   = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 accumulate,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    localparam int NUM_CHUNKS = num_chunks(BIT_WIDTH, CHUNK_WIDTH);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if ((CHUNK_WIDTH <= 0) || (BIT_WIDTH % CHUNK_WIDTH != 0)) begin : g_width_check
        $fatal(1, "serial_adder_nbit: BIT_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    state_t                 state;
    logic [BIT_WIDTH-1:0]   op_a;
    logic [BIT_WIDTH-1:0]   op_b;
    logic [BIT_WIDTH-1:0]   work;
    logic [BIT_WIDTH-1:0]   work_next;
    logic                   carry;
    logic [IDX_W-1:0]       idx;
    logic [CHUNK_WIDTH-1:0] chunk_a;
    logic [CHUNK_WIDTH-1:0] chunk_b;
    logic [CHUNK_WIDTH-1:0] chunk_sum;
    logic                   chunk_cout;

    always_comb begin
        chunk_a   = op_a[int'(idx) * CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_b   = op_b[int'(idx) * CHUNK_WIDTH +: CHUNK_WIDTH];
        work_next = work;
        work_next[int'(idx) * CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum;
    end

    adder_nbit #(
        .BIT_WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a        (chunk_a),
        .b        (chunk_b),
        .carry_in (carry),
        .sum      (chunk_sum),
        .overflow (chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sum      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            work     <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // accumulate reads the registered sum, which DONE has already updated
                        op_a  <= accumulate ? sum : a;
                        op_b  <= b;
                        carry <= carry_in;
                        idx   <= '0;
                        work  <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    work  <= work_next;
                    carry <= chunk_cout;
                    if (idx == LAST_IDX) begin
                        sum      <= work_next;
                        overflow <= chunk_cout;
                        idx      <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_sum_stable: assert property (@(posedge clk) disable iff (rst) busy |-> $stable(sum));
    a_busy_done:  assert property (@(posedge clk) disable iff (rst) !(busy && done));

endmodule
